fifo_uart_tx: RTL

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx_if.sv | 21 ++
 rtl/fifo_uart_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between an upstream FIFO and the UART transmitter.
// master = transmitter (consumes words), slave = FIFO (supplies words).
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] fifo_data_in;
    logic                  fifo_empty;
    logic                  fifo_read_ins;

    modport master (
        input  fifo_data_in,
        input  fifo_empty,
        output fifo_read_ins
    );

    modport slave (
        output fifo_data_in,
        output fifo_empty,
        input  fifo_read_ins
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from an upstream FIFO and serialises them LSB first.
// Define UART_TX_PARITY_EN to append an even-parity bit after the payload.
module fifo_uart_tx #(
    parameter int BAUD_DIV   = 434,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    fifo_uart_tx_if.master fifo,
    input  logic           enable,
    output logic           tx,
    output logic           busy,
    output logic           frame_done
);

    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state_reg, state_next;
    logic [BAUD_W-1:0]     baud_reg, baud_next;
    logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic                  tx_reg, tx_next;
    logic                  busy_reg, busy_next;
    logic                  read_reg, read_next;
    logic                  done_reg, done_next;
`ifdef UART_TX_PARITY_EN
    logic                  parity_reg, parity_next;
`endif

    logic bit_end;
    logic start_frame;
    logic data_last;
    logic stop_last;

    assign bit_end     = (baud_reg == BAUD_LAST);
    assign start_frame = enable && !fifo.fifo_empty;
    assign data_last   = bit_end && (bit_cnt_reg == DATA_LAST);
    assign stop_last   = bit_end && (bit_cnt_reg == STOP_LAST);

    // State and datapath registers; reset acts immediately, even mid-frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            read_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
            read_reg    <= read_next;
            done_reg    <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (start_frame) state_next = START;
            START:  if (bit_end) state_next = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (data_last) state_next = PARITY;
            PARITY: if (bit_end) state_next = STOP;
`else
            DATA:   if (data_last) state_next = STOP;
`endif
            STOP:   if (stop_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values for every registered output; the baud counter wraps on each bit boundary
    always_comb begin
        baud_next    = bit_end ? '0 : baud_reg + 1'b1;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        busy_next    = busy_reg;
        read_next    = 1'b0;
        done_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                baud_next    = '0;
                bit_cnt_next = '0;
                if (start_frame) begin
                    shift_next  = fifo.fifo_data_in;
                    tx_next     = 1'b0;
                    busy_next   = 1'b1;
                    read_next   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^fifo.fifo_data_in;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    tx_next      = shift_reg[0];
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (data_last) begin
                    bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                    tx_next      = parity_reg;
`else
                    tx_next      = 1'b1;
`endif
                end else if (bit_end) begin
                    shift_next   = shift_reg >> 1;
                    tx_next      = shift_next[0];
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_next      = 1'b1;
                    bit_cnt_next = '0;
                end
            end
`endif
            STOP: begin
                if (stop_last) begin
                    busy_next    = 1'b0;
                    done_next    = 1'b1;
                    bit_cnt_next = '0;
                end else if (bit_end) begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            default: begin
                baud_next = '0;
            end
        endcase
    end

    assign tx                 = tx_reg;
    assign busy               = busy_reg;
    assign frame_done         = done_reg;
    assign fifo.fifo_read_ins = read_reg;

endmodule
